// File: rtl/button_pkg.sv
// Shared constants and helpers for the push-button conditioner.
// Defaults target a 27 MHz clock with a 10 ms debounce window.
package button_pkg;

  localparam int CLK_HZ                = 27000000;
  localparam int DEBOUNCE_MS           = 10;
  localparam int STABLE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;

  // Width of a counter that must hold 0 .. stable_cycles-1; never narrower than 1 bit.
  function automatic int cnt_width(input int stable_cycles);
    int w;
    w = $clog2(stable_cycles);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/button_debounce_channel.sv
// One button channel: 2-flop synchroniser, polarity normalisation,
// stable-count filter and registered press/release pulses.
// Optional toggle register is built when BUTTON_DEBOUNCE_TOGGLE_EN is defined.
module button_debounce_channel
  import button_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press,
  // "release" is a reserved word in SystemVerilog, hence the suffix.
  output logic release_o
`ifdef BUTTON_DEBOUNCE_TOGGLE_EN
  ,
  output logic toggle
`endif
);

  localparam int            CW       = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  // Raw pin value of a button that is not pressed.
  localparam logic          RAW_IDLE = ACTIVE_LOW;

  logic          sync0_q;
  logic          sync1_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          level_q;
  logic          level_d;
  logic          press_q;
  logic          press_d;
  logic          release_q;
  logic          release_d;
  logic          s;

`ifdef BUTTON_DEBOUNCE_TOGGLE_EN
  logic          toggle_q;
  logic          toggle_d;
`endif

  // Normalised synchronised sample: 1 means pressed regardless of pin polarity.
  assign s = sync1_q ^ RAW_IDLE;

  // Stable-count filter: a change is accepted only after STABLE_CYCLES
  // consecutive disagreeing samples; any agreeing sample restarts the count.
  always_comb begin
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (s == level_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CNT_LAST) begin
      cnt_d     = '0;
      level_d   = s;
      press_d   = s;
      release_d = ~s;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
`ifdef BUTTON_DEBOUNCE_TOGGLE_EN
    toggle_d = toggle_q ^ press_d;
`endif
  end

  // State registers; reset loads the synchroniser with the idle pin level
  // so that a released button produces no spurious event after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync0_q   <= RAW_IDLE;
      sync1_q   <= RAW_IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef BUTTON_DEBOUNCE_TOGGLE_EN
      toggle_q  <= 1'b0;
`endif
    end else begin
      sync0_q   <= btn_raw;
      sync1_q   <= sync0_q;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
`ifdef BUTTON_DEBOUNCE_TOGGLE_EN
      toggle_q  <= toggle_d;
`endif
    end
  end

  assign level     = level_q;
  assign press     = press_q;
  assign release_o = release_q;
`ifdef BUTTON_DEBOUNCE_TOGGLE_EN
  assign toggle    = toggle_q;
`endif

endmodule

// File: rtl/button_debounce.sv
// Multi-channel push-button conditioner: one independent debounce channel
// per button pin. All outputs are registered.
// Optional feature macro: BUTTON_DEBOUNCE_TOGGLE_EN adds the toggle port.
module button_debounce
  import button_pkg::*;
#(
  parameter int CHANNELS      = 2,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] btn_raw,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press,
  // "release" is a reserved word in SystemVerilog, hence the suffix.
  output logic [CHANNELS-1:0] release_o
`ifdef BUTTON_DEBOUNCE_TOGGLE_EN
  ,
  output logic [CHANNELS-1:0] toggle
`endif
);

  // One fully independent channel per button.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    button_debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .btn_raw  (btn_raw[g]),
      .level    (level[g]),
      .press    (press[g]),
      .release_o(release_o[g])
`ifdef BUTTON_DEBOUNCE_TOGGLE_EN
      ,
      .toggle   (toggle[g])
`endif
    );
  end

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: CHANNELS=2, STABLE_CYCLES=4, ACTIVE_LOW=1.
// Reference model: a sliding window over the normalised, 2-cycle-delayed
// samples; a channel's level flips when the last STABLE_CYCLES samples all
// disagree with it.
module tb_button_debounce;

  localparam int             CH       = 2;
  localparam int             SC       = 4;
  localparam bit             AL       = 1'b1;
  localparam logic [CH-1:0]  IDLE_RAW = {CH{AL}};

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] btn_raw = IDLE_RAW;
  logic [CH-1:0] level;
  logic [CH-1:0] press;
  logic [CH-1:0] release_o;
`ifdef BUTTON_DEBOUNCE_TOGGLE_EN
  logic [CH-1:0] toggle;
`endif

  always #5 clk = ~clk;

  button_debounce #(
    .CHANNELS     (CH),
    .STABLE_CYCLES(SC),
    .ACTIVE_LOW   (AL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .level    (level),
    .press    (press),
    .release_o(release_o)
`ifdef BUTTON_DEBOUNCE_TOGGLE_EN
    ,
    .toggle   (toggle)
`endif
  );

  // ---------------- scoreboard state ----------------
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [4*CH-1:0] exp_q[$];
  logic [CH-1:0] raw_hist[$];
  logic [CH-1:0] s_hist[$];
  logic [CH-1:0] m_level, m_press, m_rel, m_tog;
  logic [CH-1:0] prev_pulse = '0;

  task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model, evaluated once per rising edge.
  task automatic model_edge(input logic [CH-1:0] raw, input logic r);
    if (r) begin
      raw_hist.delete();
      raw_hist.push_back(IDLE_RAW);
      raw_hist.push_back(IDLE_RAW);
      s_hist.delete();
      m_level = '0;
      m_press = '0;
      m_rel   = '0;
      m_tog   = '0;
    end else begin
      logic [CH-1:0] s;
      s = raw_hist[raw_hist.size()-2] ^ IDLE_RAW;
      s_hist.push_back(s);
      raw_hist.push_back(raw);
      if (raw_hist.size() > 2) void'(raw_hist.pop_front());
      if (s_hist.size() > SC) void'(s_hist.pop_front());
      m_press = '0;
      m_rel   = '0;
      for (int c = 0; c < CH; c++) begin
        bit all_diff;
        all_diff = (s_hist.size() >= SC);
        for (int k = 0; k < s_hist.size(); k++) begin
          if (s_hist[k][c] == m_level[c]) all_diff = 1'b0;
        end
        if (all_diff) begin
          m_level[c] = s[c];
          if (s[c]) begin
            m_press[c] = 1'b1;
            m_tog[c]   = ~m_tog[c];
          end else begin
            m_rel[c] = 1'b1;
          end
        end
      end
    end
    exp_q.push_back({m_level, m_press, m_rel, m_tog});
  endtask

  // ---------------- driver ----------------
  task automatic tick(input logic [CH-1:0] raw, input logic r);
    logic [4*CH-1:0] e;
    btn_raw = raw;
    rst     = r;
    @(posedge clk);
    model_edge(raw, r);
    #1;
    e = exp_q.pop_front();
    check("model_level",   level,     e[4*CH-1 -: CH]);
    check("model_press",   press,     e[3*CH-1 -: CH]);
    check("model_release", release_o, e[2*CH-1 -: CH]);
`ifdef BUTTON_DEBOUNCE_TOGGLE_EN
    check("model_toggle",  toggle,    e[CH-1 -: CH]);
`endif
    check("press_and_release", press & release_o, '0);
    check("back_to_back_pulse", (press | release_o) & prev_pulse, '0);
    prev_pulse = press | release_o;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [CH-1:0] raw;
    logic [CH-1:0] lvl;
    logic [CH-1:0] pr;
    logic [CH-1:0] rl;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [CH-1:0] raw, input logic [CH-1:0] lvl,
                     input logic [CH-1:0] pr, input logic [CH-1:0] rl);
    vec_t v;
    v.raw = raw;
    v.lvl = lvl;
    v.pr  = pr;
    v.rl  = rl;
    tbl.push_back(v);
  endtask

  initial begin
    logic [11:0] bounce;
    logic [CH-1:0] tgt;
    logic [CH-1:0] raw;

    // Reset with buttons released: everything zero, and stays zero.
    tick(2'b11, 1'b1);
    tick(2'b11, 1'b1);
    check("reset_level", level, 2'b00);
    check("reset_press", press, 2'b00);
    check("reset_release", release_o, 2'b00);
    for (int i = 0; i < 20; i++) begin
      tick(2'b11, 1'b0);
      check("idle_level", level, 2'b00);
    end

    // Clean press (edges 1..8), release (9..15), bounced press (16..27).
    for (int i = 1; i <= 8; i++)
      add(2'b10, (i >= 6) ? 2'b01 : 2'b00, (i == 6) ? 2'b01 : 2'b00, 2'b00);
    for (int i = 9; i <= 15; i++)
      add(2'b11, (i >= 14) ? 2'b00 : 2'b01, 2'b00, (i == 14) ? 2'b01 : 2'b00);
    bounce = 12'b0000_0000_1000; // bit (i-16): raw[0] level at edge i
    for (int i = 16; i <= 27; i++)
      add({1'b1, bounce[i-16]}, (i >= 25) ? 2'b01 : 2'b00,
          (i == 25) ? 2'b01 : 2'b00, 2'b00);
    foreach (tbl[j]) begin
      tick(tbl[j].raw, 1'b0);
      check("tbl_level", level, tbl[j].lvl);
      check("tbl_press", press, tbl[j].pr);
      check("tbl_release", release_o, tbl[j].rl);
    end

    // Simultaneous press on both channels.
    for (int i = 0; i < 10; i++) tick(2'b11, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      tick(2'b00, 1'b0);
      check("simul_press", press, (i == 6) ? 2'b11 : 2'b00);
      check("simul_level", level, (i >= 6) ? 2'b11 : 2'b00);
    end
    for (int i = 0; i < 10; i++) tick(2'b11, 1'b0);

    // Reset mid-count with the button held, then a fresh press.
    tick(2'b11, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      tick(2'b10, 1'b0);
      check("midcnt_level", level, 2'b00);
    end
    tick(2'b10, 1'b1);
    for (int i = 1; i <= 7; i++) begin
      tick(2'b10, 1'b0);
      check("fresh_press", press, (i == 6) ? 2'b01 : 2'b00);
      check("fresh_level", level, (i >= 6) ? 2'b01 : 2'b00);
    end
`ifdef BUTTON_DEBOUNCE_TOGGLE_EN
    check("toggle_1", toggle, 2'b01);
`endif
    for (int p = 2; p <= 3; p++) begin
      for (int i = 0; i < 8; i++) tick(2'b11, 1'b0);
      for (int i = 0; i < 8; i++) tick(2'b10, 1'b0);
`ifdef BUTTON_DEBOUNCE_TOGGLE_EN
      check("toggle_n", toggle, (p == 2) ? 2'b00 : 2'b01);
`endif
      check("press_n_level", level, 2'b01);
    end

    // Randomized bouncy stimulus against the model.
    tgt = IDLE_RAW;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 7) == 0) tgt[c] = ~tgt[c];
      end
      raw = tgt;
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 9) == 0) raw[c] = ~raw[c];
      end
      tick(raw, ($urandom_range(0, 499) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
# button_debounce

Parametrised multi-channel push-button conditioner between raw board button pins and user logic. Each channel is synchronised into the `clk` domain, debounced by a stable-count filter, and presented as a clean pressed level plus single-cycle press/release pulses. Polarity is configurable so active-low board buttons report as active-high "pressed". It replaces direct pin-to-logic wiring for every button input in the design.

## Interface
Parameters:
- `CHANNELS`, 2: number of independent button channels, ≥1.
- `STABLE_CYCLES`, 270000: consecutive stable cycles required to accept a change (10 ms at 27 MHz), ≥2.
- `ACTIVE_LOW`, 1: 1 means raw pin low = pressed; 0 means raw pin high = pressed.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `btn_raw` in CHANNELS: asynchronous raw button pins.
- `level` out CHANNELS: debounced state, 1 = pressed.
- `press` out CHANNELS: one-cycle pulse when `level` goes 0→1.
- `release` out CHANNELS: one-cycle pulse when `level` goes 1→0.
- `toggle` out CHANNELS: present only with `BUTTON_DEBOUNCE_TOGGLE_EN`; flips on each press.

## Operation
- Per channel: 2-flop synchroniser, then polarity normalisation to `s` (1 = pressed).
- Counter `cnt`, width `$clog2(STABLE_CYCLES)`:
  - `s == level`: `cnt` ← 0.
  - `s != level` and `cnt < STABLE_CYCLES-1`: `cnt` ← `cnt`+1.
  - `s != level` and `cnt == STABLE_CYCLES-1`: `level` ← `s`, `cnt` ← 0, and `press` or `release` asserts for exactly that one registered cycle.
- Any single-cycle return of `s` to `level` (bounce) clears `cnt`; the full count restarts.
- `press`/`release` never assert together on one channel; never two consecutive cycles.
- Channels are fully independent; simultaneous events on different channels each produce their own pulses in the same cycle.
- Counter never wraps: it saturates at the accept point and clears.

## Timing
- Reset (`rst` high at an edge): synchroniser flops ← unpressed raw value (`ACTIVE_LOW` ? 1 : 0); `level`, `press`, `release`, `toggle`, `cnt` ← 0.
- Latency: with a clean step on `btn_raw` first captured at edge 1, `level` changes and the pulse is high after edge `STABLE_CYCLES+2`; the pulse drops after the next edge.
- Minimum accepted event spacing: `STABLE_CYCLES` cycles after the synchroniser.
- Reset mid-count: the count is discarded. If a button is held through reset, it is reported as a fresh press `STABLE_CYCLES+2` cycles after `rst` deasserts.
- Outputs are all registered; no combinational path from `btn_raw`.

## Configuration
- `BUTTON_DEBOUNCE_TOGGLE_EN` defined: `toggle` port exists. Each bit is a register flipped in the cycle its `press` asserts; reset to 0; unaffected by `release`.
- Undefined: no `toggle` port and no toggle registers; all other behaviour is identical.

## Structure
- Package `button_pkg`: default `STABLE_CYCLES` constant for 27 MHz / 10 ms, the `CLK_HZ` constant 27000000, and a counter-width function.
- One sub-module `button_debounce_channel` (synchroniser, counter, pulse and toggle logic for one bit), instantiated `CHANNELS` times by a generate loop.

## Test plan
Bench uses `CHANNELS`=2, `STABLE_CYCLES`=4, `ACTIVE_LOW`=1.
- Reset with `btn_raw`=2'b11 → all outputs 0; with no input change they stay 0 for 20 cycles.
- Clean press: `btn_raw[0]` goes 1→0 before edge 1 → `level[0]`=1 and `press[0]`=1 after edge 6, `press[0]`=0 after edge 7; channel 1 is untouched.
- Bounce: `btn_raw[0]` pattern 0,0,0,1,0,0,0,0 per cycle → no `level` change until 4 stable post-sync cycles after the glitch; exactly one `press` pulse.
- Release: a held press is followed by `btn_raw[0]`=1 → `release[0]` is a single pulse 6 edges later, `level[0]`=0, and `press` is never asserted.
- Simultaneous: both bits fall at the same edge → `press`=2'b11 for one cycle, then 2'b00.
- Reset mid-count, plus toggle with the macro defined: assert `rst` at `cnt`=2 while the button is held → after release of reset, a fresh press follows 6 edges later. Three presses → `toggle[0]` reads 1, 0, 1.
